anc_nlms_seq: RTL and testbench

Time-multiplexed, parametrised NLMS adaptive noise canceller. Accepts one (noise reference, noisy signal) sample pair per valid/ready handshake and runs the FIR and the coefficient update sequentially on a single MAC, one tap per cycle. Step size is power-normalised with a shift-based NLMS approximation, and adaptation can be frozen per sample. It replaces the fully-parallel single-cycle canceller in the audio ANC path, feeding the output sample memory.

---
 rtl/anc_nlms_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_anc_nlms_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/anc_nlms_seq.sv
// Sequential NLMS adaptive noise canceller: a single MAC runs the FIR, then
// the coefficient update, one tap per cycle, for each accepted sample pair.
module anc_nlms_seq #(
  parameter int DAT_LEN    = 16,
  parameter int COEFF_LEN  = 32,
  parameter int TAP_LEN    = 32,
  parameter int COEFF_FRAC = 12,
  parameter int MU         = 4096,
  parameter int NORM_BASE  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      adapt_en,
  input  logic signed [DAT_LEN-1:0] noise_in,
  input  logic signed [DAT_LEN-1:0] desired_in,
  output logic                      out_valid,
  output logic signed [DAT_LEN-1:0] cleaned_out,
  output logic signed [DAT_LEN-1:0] y_out
);

  localparam int TAP_W    = (TAP_LEN > 1) ? $clog2(TAP_LEN) : 1;
  localparam int ACC_LEN  = COEFF_LEN + DAT_LEN + $clog2(TAP_LEN);
  localparam int PWR_LEN  = 2 * DAT_LEN + $clog2(TAP_LEN);
  localparam int SQ_LEN   = 2 * DAT_LEN;
  localparam int FP_LEN   = COEFF_LEN + DAT_LEN;
  localparam int PROD_LEN = 3 * DAT_LEN;
  localparam int SUM_LEN  = PROD_LEN + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILTER = 2'd1;
  localparam logic [1:0] S_ERROR  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic signed [DAT_LEN-1:0]   MU_S      = DAT_LEN'(MU);
  localparam logic signed [DAT_LEN-1:0]   DAT_MAX   = {1'b0, {(DAT_LEN-1){1'b1}}};
  localparam logic signed [DAT_LEN-1:0]   DAT_MIN   = {1'b1, {(DAT_LEN-1){1'b0}}};
  localparam logic signed [COEFF_LEN-1:0] COEFF_MAX = {1'b0, {(COEFF_LEN-1){1'b1}}};
  localparam logic signed [COEFF_LEN-1:0] COEFF_MIN = {1'b1, {(COEFF_LEN-1){1'b0}}};

  logic [1:0]                  state_q, state_d;
  logic [TAP_W-1:0]            k_q, k_d;
  logic signed [ACC_LEN-1:0]   acc_q, acc_d;
  logic [PWR_LEN-1:0]          pwr_q, pwr_d;
  logic signed [DAT_LEN-1:0]   d_q, d_d;
  logic                        adapt_q, adapt_d;
  logic signed [DAT_LEN-1:0]   e_q, e_d;
  logic [7:0]                  s_q, s_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [DAT_LEN-1:0]   cleaned_q, cleaned_d;
  logic signed [DAT_LEN-1:0]   y_q, y_d;

  logic signed [DAT_LEN-1:0]   dl_q    [TAP_LEN];
  logic signed [COEFF_LEN-1:0] coeff_q [TAP_LEN];

  logic                        dl_shift;
  logic                        coeff_we;
  logic                        last_k;

  logic signed [DAT_LEN-1:0]   dl_k;
  logic signed [COEFF_LEN-1:0] coeff_k;
  logic signed [FP_LEN-1:0]    fir_prod;
  logic signed [SQ_LEN-1:0]    noise_sq;
  logic signed [SQ_LEN-1:0]    last_sq;

  logic signed [ACC_LEN-1:0]   acc_sh;
  logic [ACC_LEN-DAT_LEN:0]    acc_hi;
  logic signed [DAT_LEN-1:0]   y_sat;
  logic signed [DAT_LEN:0]     diff;
  logic signed [DAT_LEN-1:0]   e_sat;

  logic [7:0]                  msb_idx;
  logic [7:0]                  norm_shift;
  logic [7:0]                  upd_shift;
  logic signed [PROD_LEN-1:0]  upd_prod;
  logic signed [PROD_LEN-1:0]  upd_sh;
  logic signed [SUM_LEN-1:0]   coeff_sum;
  logic [SUM_LEN-COEFF_LEN:0]  sum_hi;
  logic signed [COEFF_LEN-1:0] coeff_sat;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign cleaned_out = cleaned_q;
  assign y_out       = y_q;

  assign last_k   = (k_q == TAP_W'(TAP_LEN - 1));
  assign dl_k     = dl_q[k_q];
  assign coeff_k  = coeff_q[k_q];
  assign fir_prod = FP_LEN'(coeff_k) * FP_LEN'(dl_k);
  assign noise_sq = SQ_LEN'(noise_in) * SQ_LEN'(noise_in);
  assign last_sq  = SQ_LEN'(dl_q[TAP_LEN-1]) * SQ_LEN'(dl_q[TAP_LEN-1]);

  // Output estimate and error, both clamped to the sample range.
  always_comb begin
    acc_sh = acc_q >>> COEFF_FRAC;
    acc_hi = acc_sh[ACC_LEN-1:DAT_LEN-1];
    if (acc_hi == '0 || acc_hi == '1) y_sat = acc_sh[DAT_LEN-1:0];
    else                              y_sat = acc_sh[ACC_LEN-1] ? DAT_MIN : DAT_MAX;
    diff = {d_q[DAT_LEN-1], d_q} - {y_sat[DAT_LEN-1], y_sat};
    if (diff[DAT_LEN] == diff[DAT_LEN-1]) e_sat = diff[DAT_LEN-1:0];
    else                                  e_sat = diff[DAT_LEN] ? DAT_MIN : DAT_MAX;
  end

  // Power normalisation: shift grows with the MSB position above NORM_BASE.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < PWR_LEN; i++) begin
      if (pwr_q[i]) msb_idx = 8'(i);
    end
    norm_shift = (msb_idx > 8'(NORM_BASE)) ? (msb_idx - 8'(NORM_BASE)) : 8'd0;
  end

  assign upd_shift = 8'd15 + s_q;
  assign upd_prod  = PROD_LEN'(MU_S) * PROD_LEN'(e_q) * PROD_LEN'(dl_k);
  assign upd_sh    = upd_prod >>> upd_shift;

  always_comb begin
    coeff_sum = SUM_LEN'(coeff_k) + SUM_LEN'(upd_sh);
    sum_hi    = coeff_sum[SUM_LEN-1:COEFF_LEN-1];
    if (sum_hi == '0 || sum_hi == '1) coeff_sat = coeff_sum[COEFF_LEN-1:0];
    else                              coeff_sat = coeff_sum[SUM_LEN-1] ? COEFF_MIN : COEFF_MAX;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    pwr_d       = pwr_q;
    d_d         = d_q;
    adapt_d     = adapt_q;
    e_d         = e_q;
    s_d         = s_q;
    out_valid_d = 1'b0;
    cleaned_d   = cleaned_q;
    y_d         = y_q;
    dl_shift    = 1'b0;
    coeff_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dl_shift = 1'b1;
          d_d      = desired_in;
          adapt_d  = adapt_en;
          // pwr is the exact sum of squares over the delay line, so it never underflows.
          pwr_d    = pwr_q + PWR_LEN'($unsigned(noise_sq)) - PWR_LEN'($unsigned(last_sq));
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_FILTER;
        end
      end
      S_FILTER: begin
        acc_d = acc_q + ACC_LEN'(fir_prod);
        if (last_k) begin
          k_d     = '0;
          state_d = S_ERROR;
        end else begin
          k_d = k_q + TAP_W'(1);
        end
      end
      S_ERROR: begin
        y_d         = y_sat;
        cleaned_d   = e_sat;
        e_d         = e_sat;
        s_d         = norm_shift;
        out_valid_d = 1'b1;
        k_d         = '0;
        state_d     = adapt_q ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: begin
        coeff_we = 1'b1;
        if (last_k) begin
          k_d     = '0;
          state_d = S_IDLE;
        end else begin
          k_d = k_q + TAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      pwr_q       <= '0;
      d_q         <= '0;
      adapt_q     <= 1'b0;
      e_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      cleaned_q   <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      pwr_q       <= pwr_d;
      d_q         <= d_d;
      adapt_q     <= adapt_d;
      e_q         <= e_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      cleaned_q   <= cleaned_d;
      y_q         <= y_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAP_LEN; i++) begin
        dl_q[i]    <= '0;
        coeff_q[i] <= '0;
      end
    end else begin
      if (dl_shift) begin
        dl_q[0] <= noise_in;
        for (int i = 1; i < TAP_LEN; i++) dl_q[i] <= dl_q[i-1];
      end
      if (coeff_we) coeff_q[k_q] <= coeff_sat;
    end
  end

endmodule

// File: tb/tb_anc_nlms_seq.sv
// Directed bench for anc_nlms_seq with a 4-tap build: hand-computed vectors
// plus sequences for reset, handshake throughput and power tracking.
module tb_anc_nlms_seq;

  localparam int DAT  = 16;
  localparam int TAPS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic adapt_en = 1'b0;
  logic signed [DAT-1:0] noise_in = '0;
  logic signed [DAT-1:0] desired_in = '0;
  logic out_valid;
  logic signed [DAT-1:0] cleaned_out;
  logic signed [DAT-1:0] y_out;

  int checks = 0;
  int failures = 0;

  anc_nlms_seq #(
    .DAT_LEN(DAT), .COEFF_LEN(32), .TAP_LEN(TAPS),
    .COEFF_FRAC(12), .MU(4096), .NORM_BASE(20)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .adapt_en(adapt_en), .noise_in(noise_in), .desired_in(desired_in),
    .out_valid(out_valid), .cleaned_out(cleaned_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DAT-1:0] noise;
    logic signed [DAT-1:0] desired;
    logic                  adapt;
    logic signed [DAT-1:0] exp_y;
    logic signed [DAT-1:0] exp_c;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mkvec(input int n, input int d, input bit a, input int y, input int c);
    vec_t v;
    v.noise   = 16'(n);
    v.desired = 16'(d);
    v.adapt   = a;
    v.exp_y   = 16'(y);
    v.exp_c   = 16'(c);
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where in_ready is back.
  task automatic send(input int n, input int d, input bit a,
                      output int yv, output int cv, output int ov_edge,
                      output int rdy_edge, output int pulses);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    noise_in   = 16'(n);
    desired_in = 16'(d);
    adapt_en   = a;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    yv = 0; cv = 0; ov_edge = -1; rdy_edge = -1; pulses = 0;
    for (int e = 1; e <= 3 * TAPS + 10; e++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (ov_edge < 0) begin
          ov_edge = e;
          yv = int'(y_out);
          cv = int'(cleaned_out);
        end
      end
      if (in_ready) begin
        rdy_edge = e;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int yv, cv, ov_e, rdy_e, np, t;
    int idx, last_acc, bad_int, pulses, nz;
    string nm;

    // Coefficients are [65536,0,0,0] at table start, so y = sat(16 * noise).
    tbl[0]  = mkvec(1000,   0,    0, 16000,  -16000);
    tbl[1]  = mkvec(-1000,  0,    0, -16000, 16000);
    tbl[2]  = mkvec(2047,   100,  0, 32752,  -32652);
    tbl[3]  = mkvec(2048,   -100, 0, 32767,  -32768);
    tbl[4]  = mkvec(-2048,  100,  0, -32768, 32767);
    tbl[5]  = mkvec(-2049,  0,    0, -32768, 32767);
    tbl[6]  = mkvec(3,      -7,   0, 48,     -55);
    tbl[7]  = mkvec(-1,     0,    0, -16,    16);
    // s = 2 here; new coeffs [65536,-32,93,-64032] (floor on negative deltas).
    tbl[8]  = mkvec(0,      1000, 1, 0,      1000);
    tbl[9]  = mkvec(0,      0,    0, -47,    47);
    tbl[10] = mkvec(0,      0,    0, 15,     -15);

    // Reset state, including in_ready during reset.
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_cleaned", cleaned_out, 0);
    chk("reset_y", y_out, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Frozen pass with zero coefficients.
    send(1000, 500, 0, yv, cv, ov_e, rdy_e, np);
    chk("frozen_y", yv, 0);
    chk("frozen_cleaned", cv, 500);
    chk("frozen_ov_edge", ov_e, TAPS + 1);
    chk("frozen_rdy_edge", rdy_e, TAPS + 1);
    chk("frozen_pulses", np, 1);
    chk("frozen_pwr", longint'(dut.pwr_q), 1000000);

    // Asynchronous reset while the block is busy updating.
    noise_in = 16'sd16384; desired_in = 16'sd8192; adapt_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("midrun_cleaned_before_rst", cleaned_out, 8192);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_cleaned", cleaned_out, 0);
    chk("async_rst_y", y_out, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_pwr", longint'(dut.pwr_q), 0);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single adaptive update from reset.
    send(16384, 8192, 1, yv, cv, ov_e, rdy_e, np);
    chk("upd_y", yv, 0);
    chk("upd_cleaned", cv, 8192);
    chk("upd_ov_edge", ov_e, TAPS + 1);
    chk("upd_rdy_edge", rdy_e, 2 * TAPS + 1);
    chk("upd_pwr", longint'(dut.pwr_q), longint'(1) << 28);
    chk("upd_coeff0", longint'(dut.coeff_q[0]), 65536);
    for (int i = 1; i < TAPS; i++) begin
      nm = $sformatf("upd_coeff%0d", i);
      chk(nm, longint'(dut.coeff_q[i]), 0);
    end

    // Output saturation.
    send(16384, 0, 0, yv, cv, ov_e, rdy_e, np);
    chk("sat_y", yv, 32767);
    chk("sat_cleaned", cv, -32767);

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      send(int'(tbl[i].noise), int'(tbl[i].desired), tbl[i].adapt, yv, cv, ov_e, rdy_e, np);
      chk($sformatf("vec%0d_y", i), yv, int'(tbl[i].exp_y));
      chk($sformatf("vec%0d_cleaned", i), cv, int'(tbl[i].exp_c));
      chk($sformatf("vec%0d_rdy_edge", i), rdy_e, tbl[i].adapt ? 2 * TAPS + 1 : TAPS + 1);
    end

    // Handshake: in_valid held high, inputs scrambled while busy.
    do_reset();
    in_valid = 1'b1;
    idx = 0; last_acc = -1; bad_int = 0; pulses = 0; nz = 0;
    for (int cyc = 0; cyc < 300 && idx < 10; cyc++) begin
      if (out_valid) begin
        pulses++;
        if (y_out != 0 || cleaned_out != 0) nz++;
      end
      if (in_ready) begin
        noise_in = 16'(100 * (idx + 1)); desired_in = '0; adapt_en = 1'b1;
        if (idx > 0 && cyc - last_acc != 2 * TAPS + 2) bad_int++;
        last_acc = cyc;
        idx++;
      end else begin
        noise_in = 16'($urandom); desired_in = 16'($urandom); adapt_en = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    t = 0;
    while (!in_ready && t < 50) begin
      if (out_valid) begin
        pulses++;
        if (y_out != 0 || cleaned_out != 0) nz++;
      end
      @(negedge clk);
      t++;
    end
    chk("hs_accepts", idx, 10);
    chk("hs_bad_intervals", bad_int, 0);
    chk("hs_out_pulses", pulses, 10);
    chk("hs_nonzero_outputs", nz, 0);
    chk("hs_pwr", longint'(dut.pwr_q), 2940000);

    // Power tracking through fill and drain of the delay line.
    do_reset();
    for (int i = 1; i <= TAPS + 1; i++) begin
      send(1000, 0, 0, yv, cv, ov_e, rdy_e, np);
      chk($sformatf("pwr_fill%0d", i), longint'(dut.pwr_q), 64'(1000000) * ((i < TAPS) ? i : TAPS));
    end
    for (int i = 1; i <= TAPS; i++) begin
      send(0, 0, 0, yv, cv, ov_e, rdy_e, np);
      chk($sformatf("pwr_drain%0d", i), longint'(dut.pwr_q), 64'(1000000) * (TAPS - i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
